// File: rtl/vga_text_writer.sv
// vga_text_writer: streams characters into an 80x25 text RAM, tracking the cursor and
// handling CR/LF/BS/FF plus whole-screen scroll, all outputs registered.
module vga_text_writer (
    input  logic        pixel_clk,
    input  logic        data_reset,
    input  logic        char_valid,
    input  logic [15:0] char_data,
    output logic        char_ready,
    output logic [11:0] ram_addr,
    output logic [15:0] ram_wr_data,
    output logic        ram_wr_en,
    input  logic [15:0] ram_rd_data,
    output logic [4:0]  cursor_row,
    output logic [6:0]  cursor_col,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, WRITE, SCROLL_RD, SCROLL_WR, BLANK_ROW, CLEAR_ALL} state_t;
    state_t      state;
    logic [7:0]  attr;
    logic        adv;
    logic        take;
    logic [7:0]  code;
    logic [15:0] blank_in;
    logic [11:0] cur_addr;
    logic [4:0]  bs_row;
    logic [6:0]  bs_col;

    function automatic logic [11:0] addr_of(input logic [4:0] r, input logic [6:0] c);
        return {1'b0, r, 6'd0} + {3'b0, r, 4'd0} + {5'd0, c};
    endfunction

    assign take     = char_valid & char_ready;
    assign code     = char_data[7:0];
    assign blank_in = {char_data[15:8], 8'h20};
    assign cur_addr = addr_of(cursor_row, cursor_col);

    // Backspace wraps to the end of the previous row but never moves past (0,0).
    always_comb begin
        bs_col = cursor_col != 7'd0 ? cursor_col - 7'd1 : (cursor_row != 5'd0 ? 7'd79 : 7'd0);
        bs_row = (cursor_col == 7'd0 && cursor_row != 5'd0) ? cursor_row - 5'd1 : cursor_row;
    end

    always_ff @(posedge pixel_clk) begin
        if (data_reset) begin
            state       <= IDLE;
            cursor_row  <= 5'd0;
            cursor_col  <= 7'd0;
            ram_addr    <= 12'd0;
            ram_wr_data <= 16'd0;
            ram_wr_en   <= 1'b0;
            char_ready  <= 1'b0;
            busy        <= 1'b0;
            attr        <= 8'h07;
            adv         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    char_ready <= 1'b1;
                    if (take) begin
                        attr       <= char_data[15:8];
                        char_ready <= 1'b0;
                        case (code)
                            8'h0D: cursor_col <= 7'd0;
                            8'h0A: begin
                                cursor_col <= 7'd0;
                                if (cursor_row != 5'd24) begin
                                    cursor_row <= cursor_row + 5'd1;
                                end else begin
                                    state    <= SCROLL_RD;
                                    busy     <= 1'b1;
                                    ram_addr <= 12'd80;
                                end
                            end
                            8'h08: begin
                                cursor_row  <= bs_row;
                                cursor_col  <= bs_col;
                                ram_addr    <= addr_of(bs_row, bs_col);
                                ram_wr_data <= blank_in;
                                ram_wr_en   <= 1'b1;
                                adv         <= 1'b0;
                                state       <= WRITE;
                                busy        <= 1'b1;
                            end
                            8'h0C: begin
                                state       <= CLEAR_ALL;
                                busy        <= 1'b1;
                                ram_addr    <= 12'd0;
                                ram_wr_data <= blank_in;
                                ram_wr_en   <= 1'b1;
                            end
                            default: begin
                                ram_addr    <= cur_addr;
                                ram_wr_data <= char_data;
                                ram_wr_en   <= 1'b1;
                                adv         <= 1'b1;
                                state       <= WRITE;
                                busy        <= 1'b1;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    ram_wr_en <= 1'b0;
                    if (adv && cursor_col == 7'd79 && cursor_row == 5'd24) begin
                        cursor_col <= 7'd0;
                        state      <= SCROLL_RD;
                        ram_addr   <= 12'd80;
                    end else begin
                        if (adv) begin
                            cursor_col <= cursor_col == 7'd79 ? 7'd0 : cursor_col + 7'd1;
                            cursor_row <= cursor_col == 7'd79 ? cursor_row + 5'd1 : cursor_row;
                        end
                        state      <= IDLE;
                        busy       <= 1'b0;
                        char_ready <= 1'b1;
                    end
                end
                // ram_addr holds the source (a+80) here; the word read back lands at a.
                SCROLL_RD: begin
                    state       <= SCROLL_WR;
                    ram_addr    <= ram_addr - 12'd80;
                    ram_wr_data <= ram_rd_data;
                    ram_wr_en   <= 1'b1;
                end
                SCROLL_WR: begin
                    if (ram_addr == 12'd1919) begin
                        state       <= BLANK_ROW;
                        ram_addr    <= 12'd1920;
                        ram_wr_data <= {attr, 8'h20};
                    end else begin
                        state     <= SCROLL_RD;
                        ram_addr  <= ram_addr + 12'd81;
                        ram_wr_en <= 1'b0;
                    end
                end
                BLANK_ROW, CLEAR_ALL: begin
                    if (ram_addr == 12'd1999) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        char_ready <= 1'b1;
                        ram_wr_en  <= 1'b0;
                        cursor_row <= state == CLEAR_ALL ? 5'd0 : cursor_row;
                        cursor_col <= state == CLEAR_ALL ? 7'd0 : cursor_col;
                    end else begin
                        ram_addr <= ram_addr + 12'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/vga_text_writer.md
VGA_TEXT_WRITER -- requirements
Module: vga_text_writer

Interface
REQ-001 SHALL have port pixel_clk  in  1  sole clock; all logic on rising edge.
REQ-002 SHALL have port data_reset  in  1  synchronous active-high reset.
REQ-003 SHALL have port char_valid  in  1  producer offers char_data this cycle.
REQ-004 SHALL have port char_data  in  16  [15:8] attribute (14:12 bg RGB, 10:8 fg RGB), [7:0] character/control code.
REQ-005 SHALL have port char_ready  out  1  block accepts char_data this cycle.
REQ-006 SHALL have port ram_addr  out  12  text RAM word address = row*80 + col.
REQ-007 SHALL have port ram_wr_data  out  16  text RAM write word.
REQ-008 SHALL have port ram_wr_en  out  1  write strobe; low = read of ram_addr.
REQ-009 SHALL have port ram_rd_data  in  16  read word, valid one cycle after ram_addr presented with ram_wr_en=0.
REQ-010 SHALL have port cursor_row  out  5  current row, 0..24.
REQ-011 SHALL have port cursor_col  out  7  current column, 0..79.
REQ-012 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-013 SHALL drive all outputs from registers; screen fixed at 80x25, addresses 0..1999.
REQ-014 SHALL implement states IDLE, WRITE, SCROLL_RD, SCROLL_WR, BLANK_ROW, CLEAR_ALL.
REQ-015 SHALL assert char_ready only in IDLE; a transfer occurs when char_valid and char_ready are both high at a rising edge.
REQ-016 SHALL latch char_data[15:8] on every transfer as blank attribute; blank word = {attr, 8'h20}.
REQ-017 Printable (code not 08/0A/0C/0D): next cycle ram_wr_en=1, ram_addr=cursor address, ram_wr_data=char_data; state WRITE one cycle; cursor then advances; return to IDLE.
REQ-018 Advance: col<79 -> col+1; col=79 -> col 0 and row+1; row=24 with wrap -> row stays 24, enter SCROLL_RD.
REQ-019 0x0D (CR): col <- 0, no RAM write, char_ready low one cycle.
REQ-020 0x0A (LF): col <- 0; row<24 -> row+1; row=24 -> enter SCROLL_RD.
REQ-021 0x08 (BS): col>0 -> col-1; col=0,row>0 -> row-1, col 79; at (0,0) cursor unchanged; blank word written at resulting position via WRITE.
REQ-022 0x0C (FF): enter CLEAR_ALL; write blank to 0..1999 one word/cycle ascending (2000 cycles); cursor <- (0,0) on exit.
REQ-023 Scroll: for a=0..1919, SCROLL_RD presents a+80 with ram_wr_en=0; SCROLL_WR writes ram_rd_data to a; 2 cycles/word.
REQ-024 After a=1919 enter BLANK_ROW: write blank to 1920..1999, one/cycle; then IDLE; total scroll 3920 cycles.
REQ-025 SHALL keep ram_wr_en=0 in IDLE and SCROLL_RD; ram_addr holds last value when idle.
REQ-026 SHALL ignore char_valid while busy; producer holds data until ready.
REQ-027 Address arithmetic SHALL be 12-bit unsigned; no value above 1999 ever presented.

Reset
REQ-028 While data_reset high: state IDLE, cursor (0,0), ram_addr 0, ram_wr_data 0, ram_wr_en 0, char_ready 0, busy 0, attr 8'h07.
REQ-029 char_ready SHALL rise the first cycle after data_reset deasserts.
REQ-030 Reset mid-WRITE/scroll/clear SHALL abort at the next edge: no further RAM writes; RAM contents left as-is.
REQ-031 Reset SHALL take priority over a simultaneous char_valid transfer.

Verification
REQ-032 Reset, send 16'h0741 ('A') -> one write addr 0 data 16'h0741; cursor (0,1); char_ready low exactly one cycle.
REQ-033 Cursor (3,79), send 16'h1742 -> write addr 319 data 16'h1742; cursor (4,0).
REQ-034 Fill rows with row index, cursor (24,5), send 16'h070A -> busy 3920 cycles; word 0 = former 80, word 1919 = former 1999, 1920..1999 = 16'h0720; cursor (24,0).
REQ-035 Send 16'h470C -> 2000 writes of 16'h4720 at 0..1999 ascending; cursor (0,0); busy 2000 cycles.
REQ-036 Cursor (1,0), send 16'h0708 -> cursor (0,79), write addr 79 data 16'h0720; at (0,0) BS -> cursor stays, write addr 0.
REQ-037 Assert data_reset during scroll word 500 -> ram_wr_en 0 next cycle onward; outputs at REQ-028 values; ready after release.
